// File: rtl/gf_adder_pkg.sv
// Shared definitions for the GF/integer adder datapath: operation modes.
package gf_adder_pkg;
  typedef enum logic [1:0] {
    MODE_ADD    = 2'b00,
    MODE_SUB    = 2'b01,
    MODE_GF_XOR = 2'b10,
    MODE_ADDC   = 2'b11
  } mode_t;
endpackage

// File: rtl/full_adder.sv
// One-bit full adder cell.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

// File: rtl/half_adder.sv
// One-bit half adder cell.
module half_adder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);
  assign s = a ^ b;
  assign c = a & b;
endmodule

// File: rtl/rca_segment.sv
// Combinational ripple-carry segment; gf_mode kills every carry so the sum becomes a ^ b.
module rca_segment #(
  parameter int SEG_W = 8
) (
  input  logic [SEG_W-1:0] a,
  input  logic [SEG_W-1:0] b,
  input  logic             ci,
  input  logic             gf_mode,
  output logic [SEG_W-1:0] sum,
  output logic             co,
  output logic             c_msb_in
);
  logic [SEG_W:0] c;
  logic ha0_s, ha0_c, ha1_c;

  // Bit 0 is a full adder assembled from two half adders.
  assign c[0] = ci & ~gf_mode;
  half_adder u_ha0 (.a(a[0]), .b(b[0]), .s(ha0_s), .c(ha0_c));
  half_adder u_ha1 (.a(ha0_s), .b(c[0]), .s(sum[0]), .c(ha1_c));
  assign c[1] = (ha0_c | ha1_c) & ~gf_mode;

  for (genvar i = 1; i < SEG_W; i++) begin : g_fa
    logic co_raw;
    full_adder u_fa (.a(a[i]), .b(b[i]), .ci(c[i]), .s(sum[i]), .co(co_raw));
    assign c[i+1] = co_raw & ~gf_mode;
  end

  assign co       = c[SEG_W];
  assign c_msb_in = c[SEG_W-1];
endmodule

// File: rtl/pipe_rca_adder.sv
// Pipelined ripple-carry adder: one SEG_W segment per stage, carry registered between stages,
// global stall with valid/ready handshake, ADD/SUB/ADDC and carry-free GF(2^m) XOR.
module pipe_rca_adder
  import gf_adder_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_STAGES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [1:0]            in_mode,
  input  logic                  in_carry,
  input  logic [DATA_WIDTH-1:0] in_sum_a,
  input  logic [DATA_WIDTH-1:0] in_sum_b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_sum_result,
  output logic                  out_carry,
  output logic                  out_overflow
);
  localparam int SEG_W = DATA_WIDTH / NUM_STAGES;

  logic                  adv;
  logic [DATA_WIDTH-1:0] b_prep;
  logic                  cin_prep;
  logic                  gf_in;

  assign adv      = enable & ~rst & (~out_valid | out_ready);
  assign in_ready = adv;

  always_comb begin
    b_prep   = in_sum_b;
    cin_prep = 1'b0;
    gf_in    = 1'b0;
    case (mode_t'(in_mode))
      MODE_SUB:    begin b_prep = ~in_sum_b; cin_prep = 1'b1; end
      MODE_ADDC:   cin_prep = in_carry;
      MODE_GF_XOR: gf_in = 1'b1;
      default:     ;
    endcase
  end

  for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
    localparam bit LAST  = (k == NUM_STAGES - 1);
    localparam int REM_W = DATA_WIDTH - k * SEG_W;

    logic                     src_vld, src_ci, src_gf;
    logic [REM_W-1:0]         src_a_all, src_b_all;
    logic [SEG_W-1:0]         seg_sum;
    logic                     seg_co, seg_cmsb;
    logic [(k+1)*SEG_W-1:0]   res_next;
    logic                     vld_q, carry_q;
    logic [(k+1)*SEG_W-1:0]   res_q;

    // Stage k input: port operands for the first stage, skew registers of stage k-1 otherwise.
    if (k == 0) begin : g_src
      assign src_vld   = in_valid;
      assign src_ci    = cin_prep;
      assign src_gf    = gf_in;
      assign src_a_all = in_sum_a;
      assign src_b_all = b_prep;
      assign res_next  = seg_sum;
    end else begin : g_src
      assign src_vld   = g_stage[k-1].vld_q;
      assign src_ci    = g_stage[k-1].carry_q;
      assign src_gf    = g_stage[k-1].g_skew.gf_q;
      assign src_a_all = g_stage[k-1].g_skew.a_q;
      assign src_b_all = g_stage[k-1].g_skew.b_q;
      assign res_next  = {seg_sum, g_stage[k-1].res_q};
    end

    rca_segment #(.SEG_W(SEG_W)) u_seg (
      .a        (src_a_all[SEG_W-1:0]),
      .b        (src_b_all[SEG_W-1:0]),
      .ci       (src_ci),
      .gf_mode  (src_gf),
      .sum      (seg_sum),
      .co       (seg_co),
      .c_msb_in (seg_cmsb)
    );

    always_ff @(posedge clk) begin
      if (rst)      vld_q <= 1'b0;
      else if (adv) vld_q <= src_vld;
    end

    // Data loads only with a valid operand so bubbles leave the outputs untouched.
    always_ff @(posedge clk) begin
      if (rst) begin
        if (LAST) begin
          res_q   <= '0;
          carry_q <= 1'b0;
        end
      end else if (adv && src_vld) begin
        res_q   <= res_next;
        carry_q <= seg_co;
      end
    end

    if (LAST) begin : g_last
      logic ovf_q;
      always_ff @(posedge clk) begin
        if (rst)                     ovf_q <= 1'b0;
        else if (adv && src_vld)     ovf_q <= (seg_cmsb ^ seg_co) & ~src_gf;
      end
    end else begin : g_skew
      logic [REM_W-SEG_W-1:0] a_q, b_q;
      logic                   gf_q;
      logic                   unused_cmsb;
      assign unused_cmsb = seg_cmsb;
      always_ff @(posedge clk) begin
        if (adv && src_vld) begin
          a_q  <= src_a_all[REM_W-1:SEG_W];
          b_q  <= src_b_all[REM_W-1:SEG_W];
          gf_q <= src_gf;
        end
      end
    end
  end

  assign out_valid      = g_stage[NUM_STAGES-1].vld_q;
  assign out_sum_result = g_stage[NUM_STAGES-1].res_q;
  assign out_carry      = g_stage[NUM_STAGES-1].carry_q;
  assign out_overflow   = g_stage[NUM_STAGES-1].g_last.ovf_q;
endmodule

// File: tb/tb_pipe_rca_adder.sv
// Directed bench for pipe_rca_adder: main 32/4 instance plus 1-stage and 32-stage instances.
module tb_pipe_rca_adder;
  import gf_adder_pkg::*;

  logic        clk = 1'b0;
  logic        rst, enable, in_valid, in_carry, out_ready;
  logic [1:0]  in_mode;
  logic [31:0] in_sum_a, in_sum_b;
  logic        in_ready, out_valid, out_carry, out_overflow;
  logic [31:0] out_sum_result;

  logic        in_valid_x1, in_valid_x32, in_carry_x;
  logic [1:0]  mode_x;
  logic [31:0] a_x, b_x;
  logic        rdy1, vld1, c1, ovf1, rdy32, vld32, c32, ovf32;
  logic [31:0] res1, res32;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  pipe_rca_adder #(.DATA_WIDTH(32), .NUM_STAGES(4)) dut (
    .clk(clk), .rst(rst), .enable(enable), .in_valid(in_valid), .in_ready(in_ready),
    .in_mode(in_mode), .in_carry(in_carry), .in_sum_a(in_sum_a), .in_sum_b(in_sum_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum_result(out_sum_result),
    .out_carry(out_carry), .out_overflow(out_overflow));

  pipe_rca_adder #(.DATA_WIDTH(32), .NUM_STAGES(1)) dut1 (
    .clk(clk), .rst(rst), .enable(enable), .in_valid(in_valid_x1), .in_ready(rdy1),
    .in_mode(mode_x), .in_carry(in_carry_x), .in_sum_a(a_x), .in_sum_b(b_x),
    .out_valid(vld1), .out_ready(out_ready), .out_sum_result(res1),
    .out_carry(c1), .out_overflow(ovf1));

  pipe_rca_adder #(.DATA_WIDTH(32), .NUM_STAGES(32)) dut32 (
    .clk(clk), .rst(rst), .enable(enable), .in_valid(in_valid_x32), .in_ready(rdy32),
    .in_mode(mode_x), .in_carry(in_carry_x), .in_sum_a(a_x), .in_sum_b(b_x),
    .out_valid(vld32), .out_ready(out_ready), .out_sum_result(res32),
    .out_carry(c32), .out_overflow(ovf32));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one operation into an empty pipeline and check result, flags and latency.
  task automatic run_one(input string tag, input logic [1:0] mode, input logic [31:0] a,
                         input logic [31:0] b, input logic cin, input logic [31:0] exp_res,
                         input logic exp_c, input logic exp_ovf);
    int k;
    in_mode = mode; in_sum_a = a; in_sum_b = b; in_carry = cin; in_valid = 1'b1;
    #1;
    check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    step();
    in_valid = 1'b0;
    k = 0;
    while (!out_valid && k < 20) begin
      step();
      k++;
    end
    check({tag, "_latency"}, 64'(k), 64'd3);
    check({tag, "_result"}, 64'(out_sum_result), 64'(exp_res));
    check({tag, "_carry"}, 64'(out_carry), 64'(exp_c));
    check({tag, "_ovf"}, 64'(out_overflow), 64'(exp_ovf));
    step();
    check({tag, "_retired"}, 64'(out_valid), 64'd0);
    check({tag, "_hold"}, 64'(out_sum_result), 64'(exp_res));
  endtask

  initial begin
    logic [32:0] q[$];
    logic [32:0] exp33;
    logic [31:0] held;
    logic        stalled, xfer;
    int sent, got, k, lat1, lat32;

    rst = 1'b1; enable = 1'b1; in_valid = 1'b0; in_carry = 1'b0; out_ready = 1'b1;
    in_mode = MODE_ADD; in_sum_a = '0; in_sum_b = '0;
    in_valid_x1 = 1'b0; in_valid_x32 = 1'b0; in_carry_x = 1'b0; mode_x = MODE_ADD;
    a_x = '0; b_x = '0;
    step(); step();
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_result", 64'(out_sum_result), 64'd0);
    check("rst_carry", 64'(out_carry), 64'd0);
    check("rst_ovf", 64'(out_overflow), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", 64'(in_ready), 64'd1);

    run_one("add_wrap", MODE_ADD, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
    run_one("sub_ovf", MODE_SUB, 32'h8000_0000, 32'h0000_0001, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1);
    run_one("sub_borrow", MODE_SUB, 32'h0000_0000, 32'h0000_0001, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0);
    run_one("gf_xor", MODE_GF_XOR, 32'hDEAD_BEEF, 32'hFFFF_0000, 1'b1, 32'h2152_BEEF, 1'b0, 1'b0);
    run_one("gf_noripple", MODE_GF_XOR, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b0);
    run_one("addc", MODE_ADDC, 32'h7FFF_FFFF, 32'h0000_0000, 1'b1, 32'h8000_0000, 1'b0, 1'b1);
    run_one("add_carry_ignored", MODE_ADD, 32'h0000_00FF, 32'h0000_0001, 1'b1, 32'h0000_0100, 1'b0, 1'b0);

    // Streaming with out_ready pattern 1,0,0,1.
    sent = 0; got = 0; stalled = 1'b0; held = '0;
    for (int cyc = 0; cyc < 300 && got < 16; cyc++) begin
      out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
      if (sent < 16 && !in_valid) begin
        in_valid = 1'b1;
        in_mode  = ($urandom_range(0, 1) == 1) ? MODE_ADDC : MODE_ADD;
        in_sum_a = $urandom; in_sum_b = $urandom; in_carry = 1'($urandom_range(0, 1));
      end
      #1;
      if (stalled) begin
        check("stall_valid_hold", 64'(out_valid), 64'd1);
        check("stall_result_hold", 64'(out_sum_result), 64'(held));
      end
      if (out_valid && !out_ready) check("full_in_ready_low", 64'(in_ready), 64'd0);
      if (out_valid && out_ready) begin
        if (q.size() == 0) check("stream_unexpected_output", 64'd1, 64'd0);
        else begin
          exp33 = q.pop_front();
          check("stream_result", 64'(out_sum_result), 64'(exp33[31:0]));
          check("stream_carry", 64'(out_carry), 64'(exp33[32]));
        end
        got++;
      end
      stalled = out_valid && !out_ready;
      held = out_sum_result;
      xfer = in_valid && in_ready;
      if (xfer) begin
        exp33 = {1'b0, in_sum_a} + {1'b0, in_sum_b} +
                33'((in_mode == MODE_ADDC) ? in_carry : 1'b0);
        q.push_back(exp33);
        sent++;
      end
      step();
      if (xfer) in_valid = 1'b0;
    end
    check("stream_count", 64'(got), 64'd16);
    check("stream_queue_empty", 64'(q.size()), 64'd0);
    out_ready = 1'b1;
    step(); step(); step(); step();

    // enable = 0 freezes in-flight data and overrides out_ready.
    in_mode = MODE_ADD; in_sum_a = 32'h1234_5678; in_sum_b = 32'h1111_1111; in_valid = 1'b1;
    step();
    in_valid = 1'b0; enable = 1'b0;
    for (int i = 0; i < 5; i++) step();
    check("en_frozen_valid", 64'(out_valid), 64'd0);
    check("en_in_ready", 64'(in_ready), 64'd0);
    enable = 1'b1;
    k = 0;
    while (!out_valid && k < 20) begin step(); k++; end
    check("en_resume_latency", 64'(k), 64'd3);
    enable = 1'b0;
    step(); step();
    check("en_hold_valid", 64'(out_valid), 64'd1);
    check("en_hold_result", 64'(out_sum_result), 64'h2345_6789);
    enable = 1'b1;
    step();
    check("en_retire", 64'(out_valid), 64'd0);

    // Reset with three operations in flight.
    in_mode = MODE_ADD; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_sum_a = 32'(i + 10); in_sum_b = 32'(i + 20);
      step();
    end
    in_valid = 1'b0; rst = 1'b1;
    step();
    check("midrst_valid", 64'(out_valid), 64'd0);
    rst = 1'b0;
    k = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (out_valid) k++;
    end
    check("midrst_no_stale", 64'(k), 64'd0);
    run_one("post_rst_add", MODE_ADD, 32'h5, 32'h3, 1'b0, 32'h8, 1'b0, 1'b0);

    // 1-stage and 32-stage variants: ADDC 0x7FFF_FFFF + 0 + 1.
    mode_x = MODE_ADDC; a_x = 32'h7FFF_FFFF; b_x = '0; in_carry_x = 1'b1;
    in_valid_x1 = 1'b1; in_valid_x32 = 1'b1;
    step();
    in_valid_x1 = 1'b0; in_valid_x32 = 1'b0;
    lat1 = -1; lat32 = -1;
    for (int i = 0; i < 40 && (lat1 < 0 || lat32 < 0); i++) begin
      if (vld1 && lat1 < 0) begin
        lat1 = i;
        check("s1_result", 64'(res1), 64'h8000_0000);
        check("s1_ovf", 64'(ovf1), 64'd1);
        check("s1_carry", 64'(c1), 64'd0);
      end
      if (vld32 && lat32 < 0) begin
        lat32 = i;
        check("s32_result", 64'(res32), 64'h8000_0000);
        check("s32_ovf", 64'(ovf32), 64'd1);
        check("s32_carry", 64'(c32), 64'd0);
      end
      step();
    end
    check("s1_latency", 64'(lat1), 64'd0);
    check("s32_latency", 64'(lat32), 64'd31);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/pipe_rca_adder.md
# pipe_rca_adder

Parametrised, pipelined successor to the single-cycle ripple-carry adder. It splits a DATA_WIDTH operand into NUM_STAGES equal segments and ripples the carry one segment per clock, so wide adders close timing at full throughput. It adds a valid/ready handshake with back-pressure, a subtract mode, and a GF(2^m) addition mode that performs carry-free XOR. It sits in the sequential datapath next to the GF multipliers and reducers.

## Interface
- DATA_WIDTH, 32, operand/result width; must be a multiple of NUM_STAGES.
- NUM_STAGES, 4, pipeline segments; 1..DATA_WIDTH; SEG_W = DATA_WIDTH/NUM_STAGES.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  global advance gate; low freezes the whole pipeline.
- in_valid  in  1  operands valid.
- in_ready  out  1  pipeline accepts this cycle.
- in_mode  in  2  00 ADD, 01 SUB, 10 GF_XOR, 11 ADDC.
- in_carry  in  1  carry-in; used only in ADDC.
- in_sum_a  in  DATA_WIDTH  operand A.
- in_sum_b  in  DATA_WIDTH  operand B.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts.
- out_sum_result  out  DATA_WIDTH  result.
- out_carry  out  1  carry out of the MSB; for SUB, 1 = no borrow.
- out_overflow  out  1  two's-complement signed overflow.

## Operation
- Advance condition: adv = enable & ~rst & (~out_valid | out_ready). in_ready = adv (combinational). A transfer occurs on in_valid & in_ready.
- All stage registers update only when adv = 1. When adv = 0, every stage holds. There are no bubbles squeezed out; the stall is global.
- Operand preparation at entry:
  - ADD: b' = b, cin = 0.
  - SUB: b' = ~b, cin = 1.
  - ADDC: b' = b, cin = in_carry.
  - GF_XOR: b' = b, cin = 0, carry chain forced to 0 in every segment.
- Stage k (0..NUM_STAGES-1) computes segment k bits [k*SEG_W +: SEG_W] using the carry registered from stage k-1 (cin for k = 0).
- Each stage carries forward its valid bit, mode, partial result, carry, and the not-yet-consumed upper operand segments (skew registers).
- Final stage outputs:
  - out_sum_result = concatenated segments.
  - out_carry = last segment carry-out.
  - out_overflow = carry into MSB XOR carry out of MSB.
  - out_carry and out_overflow are forced to 0 in GF_XOR mode.
- Arithmetic is modulo 2^DATA_WIDTH; no saturation.
- A bubble (in_valid = 0 while adv = 1) propagates as valid = 0. Data registers may load don't-care values, but out_sum_result, out_carry and out_overflow must not change while out_valid = 0 after reset.

## Timing
- Latency: an operand accepted at edge T produces out_valid = 1 after edge T+NUM_STAGES-1, provided there is no stall.
- Throughput: one result per cycle when out_ready = 1 and enable = 1.
- NUM_STAGES = 1 gives a one-cycle registered adder.
- Reset: out_valid = 0, all stage valid bits = 0, out_sum_result = 0, out_carry = 0, out_overflow = 0. in_ready = 0 while rst = 1.
- Reset mid-operation discards all in-flight operands; no partial result is emitted.
- Pipeline full, out_valid = 1 and out_ready = 0: in_ready = 0, and outputs are held stable until accepted.
- Simultaneous out_ready = 1 and in_valid = 1 with a full pipeline: the output retires and the new operand enters on the same edge.
- enable = 0 overrides out_ready: nothing retires, and outputs stay stable.

## Structure
- Shared package gf_adder_pkg: mode constants MODE_ADD, MODE_SUB, MODE_GF_XOR, MODE_ADDC, and the 2-bit mode typedef.
- Sub-module rca_segment (SEG_W): a combinational segment adder built from the existing half_adder and full_adder cells.
  - Inputs: a, b, ci, gf_mode.
  - Outputs: sum, co, c_msb_in (carry into the top bit, used for overflow).
  - gf_mode masks every internal carry to 0.
- Top level: a generate loop of NUM_STAGES segments plus stage/skew registers and the handshake logic.

## Test plan
All cases use DATA_WIDTH = 32, NUM_STAGES = 4 unless stated.
- ADD of 0xFFFF_FFFF and 0x0000_0001, out_ready = 1 → after 4 cycles result 0x0000_0000, out_carry = 1, out_overflow = 0.
- SUB of 0x8000_0000 and 0x0000_0001 → result 0x7FFF_FFFF, out_carry = 1, out_overflow = 1. SUB of 0x0 and 0x1 → result 0xFFFF_FFFF, out_carry = 0.
- GF_XOR of 0xDEAD_BEEF and 0xFFFF_0000 → result 0x2152_BEEF, out_carry = 0, out_overflow = 0, even when segment carries would ripple.
- Back-to-back stream of 16 random ADD/ADDC operations with out_ready toggling 1,0,0,1 → results in order, none lost or duplicated, outputs stable while stalled, in_ready low when full.
- Assert rst with 3 operations in flight → out_valid = 0 on the next cycle, no stale result emitted. The first post-reset operation (0x5 + 0x3) produces 0x8 after 4 cycles.
- NUM_STAGES = 1 and NUM_STAGES = 32: ADDC of 0x7FFF_FFFF, 0x0, in_carry = 1 → result 0x8000_0000, out_overflow = 1, with latency 1 and 32 respectively.
